lcd_write_arbiter: RTL and testbench
====================================

Name: lcd_write_arbiter

Overview:
- Sequences the board's 4-bit character LCD (E/RS/RW/D[3:0], StrataFlash disable line) on behalf of two requesters: the MiniAlu LCD instruction path (data bytes, RS=1) and a command port (control bytes, RS=0).
- Runs the power-on init sequence itself, then arbitrates requests round-robin and splits each byte into two timed nibble strobes.
- Sits between the core's decode/stall logic and the LCD pins, replacing ad-hoc timing in the core.

Parameters:
- T_POWERUP, 750000, cycles waited after reset before the first init nibble (15 ms at 50 MHz).
- T_INIT_LONG, 205000, wait after the first init nibble (4.1 ms).
- T_INIT_SHORT, 5000, wait after the second init nibble (100 us).
- T_ENABLE, 12, cycles E is held high per nibble.
- T_NIBBLE_GAP, 50, cycles between the high- and low-nibble strobes of one byte (1 us).
- T_BYTE_GAP, 2000, cycles after a byte completes, and after init nibbles 3 and 4 (40 us).
- T_CLEAR, 82000, post-byte wait used instead of T_BYTE_GAP when RS=0 and byte is 8'h01 or 8'h02.

Ports:
- Clock  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- iReqCpu  in  1  CPU data-byte request, level, held until ack
- iCpuData  in  8  CPU byte, sent with RS=1
- iReqCmd  in  1  command request, level, held until ack
- iCmdData  in  8  command byte, sent with RS=0
- oAckCpu  out  1  1-cycle pulse: CPU byte latched
- oAckCmd  out  1  1-cycle pulse: command byte latched
- oReady  out  1  high only in IDLE after init completes
- oLCD_E  out  1  LCD enable strobe
- oLCD_RS  out  1  register select
- oLCD_RW  out  1  constant 0 (write only)
- oLCD_SF_CE  out  1  constant 1 (StrataFlash disabled)
- oLCD_Data  out  4  nibble bus

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset values: oAckCpu=0, oAckCmd=0, oReady=0, oLCD_E=0, oLCD_RS=0, oLCD_Data=0, oLCD_RW=0, oLCD_SF_CE=1. State goes to PWR_WAIT; the round-robin pointer points at CPU.
- Reset asserted mid-byte or mid-init aborts on that edge: E drops, and the full init sequence reruns.
- States: PWR_WAIT, INIT_NIB, INIT_WAIT, CFG, IDLE, SETUP, E_HIGH, HOLD, GAP.
- Init sequence:
  - Wait T_POWERUP.
  - Strobe nibbles 3, 3, 3, 2 (RS=0), followed by waits of T_INIT_LONG, T_INIT_SHORT, T_BYTE_GAP and T_BYTE_GAP respectively.
  - CFG then sends bytes 28, 06, 0C, 01 (RS=0) through the normal byte path. The 01 byte uses T_CLEAR.
  - Enter IDLE.
- Requests raised during init are held off: no ack is issued until the first IDLE cycle.
- IDLE arbitration:
  - Exactly one requester high: grant it.
  - Both high: grant the one not served last. The pointer reset value (CPU) means the first contention goes to the command port.
  - The pointer updates on every grant.
- Grant cycle (IDLE, request high):
  - Latch byte and RS.
  - Pulse the matching ack for exactly that cycle; oReady drops in the same cycle.
  - Next state is SETUP.
- A request dropped before its ack has no effect. A requester holding its request after the ack is treated as a new byte at the next IDLE.
- Byte path:
  - SETUP (1 cycle): Data = high nibble, RS valid, E=0.
  - E_HIGH (T_ENABLE cycles): E=1.
  - HOLD (1 cycle): E=0, Data stable.
  - GAP (T_NIBBLE_GAP cycles).
  - SETUP/E_HIGH/HOLD repeat for the low nibble.
  - GAP (T_BYTE_GAP, or T_CLEAR for RS=0 with byte 01/02).
  - Return to IDLE, or to CFG while init is in progress.
- Counters are wide enough for the largest parameter. A counter loads N-1 and terminates on 0, so a wait of N cycles is exact.
- Handshake latency: the ack follows the request by 1 cycle from IDLE. Minimum issue-to-issue for back-to-back bytes = 2*(T_ENABLE+2) + T_NIBBLE_GAP + T_BYTE_GAP + 1 cycles.
- oLCD_RS and oLCD_Data change only while E=0.

Optional Feature:
- Macro: LCD_LINE_WRAP_EN.
- Defined:
  - A 5-bit column counter counts CPU data bytes and is reset by reset and by any command byte.
  - After the 16th data byte, the controller autonomously sends command C0 (line 2) before the next grant.
  - After the 32nd, it sends 80 and clears the counter.
  - The inserted byte generates no ack and wins over both requesters.
- Undefined: no counter and no inserted commands; the display wraps per the LCD's native addressing.

Test Plan:
- Init sequence: T_POWERUP=20, T_INIT_LONG=10, T_INIT_SHORT=6, T_ENABLE=3, T_NIBBLE_GAP=4, T_BYTE_GAP=8, T_CLEAR=30. Release reset, then check:
  - Nibbles 3,3,3,2, then 2/8, 0/6, 0/C, 0/1 appear on oLCD_Data with RS=0.
  - E pulses last exactly 3 cycles.
  - oReady first rises after the 30-cycle clear wait.
- Single write: iReqCpu=1, iCpuData=8'h41 in IDLE. Expect oAckCpu one cycle later, RS=1, nibble 4 strobe then nibble 1 strobe, and oReady back high after the scaled byte time.
- Contention: iReqCpu and iReqCmd high with 8'h55 / 8'h80. Expect command first (ack Cmd, RS=0 80), then CPU (RS=1 55). On the next contention, CPU wins.
- Clear timing: command 8'h01 after init. Expect a 30-cycle post-byte gap before oReady, versus 8 cycles for command 8'h0C.
- Reset mid-byte: assert Reset for 1 cycle while oLCD_E=1. Expect E=0, acks=0 and oReady=0 the next cycle, then a full init rerun.
- LCD_LINE_WRAP_EN defined: 17 CPU writes. Expect command C0 inserted (no ack) between bytes 16 and 17. After 32 data bytes, expect 80 inserted.

Source files
------------

// File: rtl/lcd_write_arbiter_if.sv
// lcd_write_arbiter_if
//   Request/ack handshake from the CPU data path and the command port, plus
//   the character-LCD pin bundle driven by the arbiter.
//   slave  : the arbiter (consumes requests, drives acks and LCD pins)
//   master : the requesters / board side
interface lcd_write_arbiter_if;
   logic       iReqCpu;     // CPU data-byte request, level, held until ack
   logic [7:0] iCpuData;    // CPU byte, sent with RS=1
   logic       iReqCmd;     // command request, level, held until ack
   logic [7:0] iCmdData;    // command byte, sent with RS=0
   logic       oAckCpu;     // 1-cycle pulse: CPU byte latched
   logic       oAckCmd;     // 1-cycle pulse: command byte latched
   logic       oReady;      // idle and init complete
   logic       oLCD_E;      // LCD enable strobe
   logic       oLCD_RS;     // register select
   logic       oLCD_RW;     // always write
   logic       oLCD_SF_CE;  // StrataFlash held disabled
   logic [3:0] oLCD_Data;   // nibble bus

   modport slave (
      input  iReqCpu, iCpuData, iReqCmd, iCmdData,
      output oAckCpu, oAckCmd, oReady,
             oLCD_E, oLCD_RS, oLCD_RW, oLCD_SF_CE, oLCD_Data
   );

   modport master (
      output iReqCpu, iCpuData, iReqCmd, iCmdData,
      input  oAckCpu, oAckCmd, oReady,
             oLCD_E, oLCD_RS, oLCD_RW, oLCD_SF_CE, oLCD_Data
   );
endinterface

// File: rtl/lcd_write_arbiter.sv
// lcd_write_arbiter
//   Drives the 4-bit character LCD for two requesters. After reset it runs
//   the power-on init (nibbles 3,3,3,2 then bytes 28,06,0C,01), then
//   arbitrates CPU data bytes (RS=1) and command bytes (RS=0) round-robin,
//   sending each byte as a high-nibble and a low-nibble E strobe.
// Ports:
//   Clock  - system clock
//   Reset  - synchronous, active-high; aborts any transfer and reruns init
//   bus    - lcd_write_arbiter_if.slave: request/ack handshakes + LCD pins
// Optional build macro:
//   LCD_LINE_WRAP_EN - counts CPU data bytes and inserts C0 after the 16th
//                      and 80 after the 32nd (no ack, beats both requesters).
module lcd_write_arbiter #(
   parameter int T_POWERUP    = 750000,
   parameter int T_INIT_LONG  = 205000,
   parameter int T_INIT_SHORT = 5000,
   parameter int T_ENABLE     = 12,
   parameter int T_NIBBLE_GAP = 50,
   parameter int T_BYTE_GAP   = 2000,
   parameter int T_CLEAR      = 82000
) (
   input logic Clock,
   input logic Reset,
   lcd_write_arbiter_if.slave bus
);

   localparam int M0    = (T_POWERUP > T_INIT_LONG) ? T_POWERUP : T_INIT_LONG;
   localparam int M1    = (M0 > T_INIT_SHORT) ? M0 : T_INIT_SHORT;
   localparam int M2    = (M1 > T_ENABLE) ? M1 : T_ENABLE;
   localparam int M3    = (M2 > T_NIBBLE_GAP) ? M2 : T_NIBBLE_GAP;
   localparam int M4    = (M3 > T_BYTE_GAP) ? M3 : T_BYTE_GAP;
   localparam int T_MAX = (M4 > T_CLEAR) ? M4 : T_CLEAR;
   localparam int CW    = $clog2(T_MAX + 1);

   typedef logic [CW-1:0] cnt_t;

   // Counters load N-1 and terminate on zero, giving exactly N cycles.
   localparam cnt_t L_PU  = cnt_t'(T_POWERUP - 1);
   localparam cnt_t L_IL  = cnt_t'(T_INIT_LONG - 1);
   localparam cnt_t L_IS  = cnt_t'(T_INIT_SHORT - 1);
   localparam cnt_t L_EN  = cnt_t'(T_ENABLE - 1);
   localparam cnt_t L_NG  = cnt_t'(T_NIBBLE_GAP - 1);
   localparam cnt_t L_BG  = cnt_t'(T_BYTE_GAP - 1);
   localparam cnt_t L_CLR = cnt_t'(T_CLEAR - 1);

   typedef enum logic [3:0] {
      PWR_WAIT, INIT_NIB, INIT_WAIT, CFG, IDLE, SETUP, E_HIGH, HOLD, GAP
   } state_t;

   // Which strobe is in flight: a bare init nibble, or half of a byte.
   typedef enum logic [1:0] {PH_INIT, PH_HI, PH_LO} phase_t;

   function automatic logic [7:0] cfg_byte(input logic [2:0] idx);
      case (idx)
         3'd0:    cfg_byte = 8'h28;
         3'd1:    cfg_byte = 8'h06;
         3'd2:    cfg_byte = 8'h0C;
         default: cfg_byte = 8'h01;
      endcase
   endfunction

   state_t     state, state_d;
   phase_t     phase, phase_d;
   cnt_t       cnt, cnt_d;
   logic [7:0] byte_q, byte_d;
   logic       rs_q, rs_d;
   logic [3:0] nib_q, nib_d;
   logic [1:0] init_idx, init_idx_d;
   logic [2:0] cfg_idx, cfg_idx_d;
   logic       init_done, done_d;
   logic       ptr_cmd, ptr_d;       // 1: command port was served last
   logic       ack_cpu_q, ack_cpu_d;
   logic       ack_cmd_q, ack_cmd_d;
   logic       grant_cmd, grant_cpu, is_clr;
   logic [7:0] cfg_b;
`ifdef LCD_LINE_WRAP_EN
   logic [4:0] col_q, col_d;
   logic       pend_q, pend_d;
   logic [7:0] ins_q, ins_d;
`endif

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state     <= PWR_WAIT;
         phase     <= PH_INIT;
         cnt       <= L_PU;
         byte_q    <= '0;
         rs_q      <= 1'b0;
         nib_q     <= '0;
         init_idx  <= '0;
         cfg_idx   <= '0;
         init_done <= 1'b0;
         ptr_cmd   <= 1'b0;
         ack_cpu_q <= 1'b0;
         ack_cmd_q <= 1'b0;
`ifdef LCD_LINE_WRAP_EN
         col_q     <= '0;
         pend_q    <= 1'b0;
         ins_q     <= '0;
`endif
      end else begin
         state     <= state_d;
         phase     <= phase_d;
         cnt       <= cnt_d;
         byte_q    <= byte_d;
         rs_q      <= rs_d;
         nib_q     <= nib_d;
         init_idx  <= init_idx_d;
         cfg_idx   <= cfg_idx_d;
         init_done <= done_d;
         ptr_cmd   <= ptr_d;
         ack_cpu_q <= ack_cpu_d;
         ack_cmd_q <= ack_cmd_d;
`ifdef LCD_LINE_WRAP_EN
         col_q     <= col_d;
         pend_q    <= pend_d;
         ins_q     <= ins_d;
`endif
      end
   end

   always_comb begin
      state_d    = state;
      phase_d    = phase;
      cnt_d      = cnt;
      byte_d     = byte_q;
      rs_d       = rs_q;
      nib_d      = nib_q;
      init_idx_d = init_idx;
      cfg_idx_d  = cfg_idx;
      done_d     = init_done;
      ptr_d      = ptr_cmd;
      ack_cpu_d  = 1'b0;
      ack_cmd_d  = 1'b0;
`ifdef LCD_LINE_WRAP_EN
      col_d      = col_q;
      pend_d     = pend_q;
      ins_d      = ins_q;
`endif
      // Under contention the port not served last wins.
      grant_cmd  = bus.iReqCmd && (!bus.iReqCpu || !ptr_cmd);
      grant_cpu  = bus.iReqCpu && !grant_cmd;
      is_clr     = !rs_q && (byte_q == 8'h01 || byte_q == 8'h02);
      cfg_b      = cfg_byte(cfg_idx);

      case (state)
         PWR_WAIT: begin
            if (cnt == '0) begin
               state_d = INIT_NIB;
               phase_d = PH_INIT;
               nib_d   = 4'h3;
               rs_d    = 1'b0;
            end else cnt_d = cnt - 1'b1;
         end
         INIT_NIB: begin
            state_d = E_HIGH;
            cnt_d   = L_EN;
         end
         INIT_WAIT: begin
            if (cnt == '0) begin
               if (init_idx == 2'd3) state_d = CFG;
               else begin
                  state_d    = INIT_NIB;
                  init_idx_d = init_idx + 2'd1;
                  nib_d      = (init_idx == 2'd2) ? 4'h2 : 4'h3;
               end
            end else cnt_d = cnt - 1'b1;
         end
         CFG: begin
            byte_d    = cfg_b;
            rs_d      = 1'b0;
            nib_d     = cfg_b[7:4];
            phase_d   = PH_HI;
            cfg_idx_d = cfg_idx + 3'd1;
            state_d   = SETUP;
         end
         IDLE: begin
`ifdef LCD_LINE_WRAP_EN
            if (pend_q) begin
               byte_d  = ins_q;
               rs_d    = 1'b0;
               nib_d   = ins_q[7:4];
               phase_d = PH_HI;
               pend_d  = 1'b0;
               state_d = SETUP;
            end else
`endif
            if (grant_cmd) begin
               byte_d    = bus.iCmdData;
               rs_d      = 1'b0;
               nib_d     = bus.iCmdData[7:4];
               phase_d   = PH_HI;
               ptr_d     = 1'b1;
               ack_cmd_d = 1'b1;
               state_d   = SETUP;
`ifdef LCD_LINE_WRAP_EN
               col_d     = '0;
`endif
            end else if (grant_cpu) begin
               byte_d    = bus.iCpuData;
               rs_d      = 1'b1;
               nib_d     = bus.iCpuData[7:4];
               phase_d   = PH_HI;
               ptr_d     = 1'b0;
               ack_cpu_d = 1'b1;
               state_d   = SETUP;
`ifdef LCD_LINE_WRAP_EN
               // 5-bit count wraps to 0 on the 32nd byte by itself.
               col_d = col_q + 5'd1;
               if (col_q == 5'd15) begin
                  pend_d = 1'b1;
                  ins_d  = 8'hC0;
               end else if (col_q == 5'd31) begin
                  pend_d = 1'b1;
                  ins_d  = 8'h80;
               end
`endif
            end
         end
         SETUP: begin
            state_d = E_HIGH;
            cnt_d   = L_EN;
         end
         E_HIGH: begin
            if (cnt == '0) state_d = HOLD;
            else cnt_d = cnt - 1'b1;
         end
         HOLD: begin
            case (phase)
               PH_INIT: begin
                  state_d = INIT_WAIT;
                  case (init_idx)
                     2'd0:    cnt_d = L_IL;
                     2'd1:    cnt_d = L_IS;
                     default: cnt_d = L_BG;
                  endcase
               end
               PH_HI: begin
                  state_d = GAP;
                  cnt_d   = L_NG;
               end
               default: begin
                  state_d = GAP;
                  cnt_d   = is_clr ? L_CLR : L_BG;
               end
            endcase
         end
         GAP: begin
            if (cnt == '0) begin
               if (phase == PH_HI) begin
                  state_d = SETUP;
                  phase_d = PH_LO;
                  nib_d   = byte_q[3:0];
               end else if (init_done) begin
                  state_d = IDLE;
               end else if (cfg_idx == 3'd4) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = CFG;
               end
            end else cnt_d = cnt - 1'b1;
         end
         default: state_d = PWR_WAIT;
      endcase
   end

   assign bus.oAckCpu    = ack_cpu_q;
   assign bus.oAckCmd    = ack_cmd_q;
   assign bus.oReady     = (state == IDLE);
   assign bus.oLCD_E     = (state == E_HIGH);
   assign bus.oLCD_RS    = rs_q;
   assign bus.oLCD_Data  = nib_q;
   assign bus.oLCD_RW    = 1'b0;
   assign bus.oLCD_SF_CE = 1'b1;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// tb_lcd_write_arbiter
//   Scoreboard bench: expected {RS,byte} pushed when a request is raised,
//   popped when the monitor reassembles a byte from two E strobes.
module tb_lcd_write_arbiter;
   localparam int T_PU  = 20;
   localparam int T_IL  = 10;
   localparam int T_IS  = 6;
   localparam int T_EN  = 3;
   localparam int T_NG  = 4;
   localparam int T_BG  = 8;
   localparam int T_CLR = 30;
   // Cycles from the first PWR_WAIT cycle to the first IDLE cycle.
   localparam int INIT_CYC = T_PU + 4*(T_EN+2) + T_IL + T_IS + 2*T_BG
                           + 4*(2*(T_EN+2) + T_NG + 1) + 3*T_BG + T_CLR;
   // Cycles from the negedge after the ack to the next IDLE negedge.
   localparam int BYTE_RDY = 2*(T_EN+2) + T_NG + T_BG - 1;
   localparam int CLR_RDY  = 2*(T_EN+2) + T_NG + T_CLR - 1;

   logic Clock = 1'b0;
   logic Reset = 1'b1;
   always #5 Clock = ~Clock;

   lcd_write_arbiter_if bus();

   lcd_write_arbiter #(
      .T_POWERUP(T_PU), .T_INIT_LONG(T_IL), .T_INIT_SHORT(T_IS),
      .T_ENABLE(T_EN), .T_NIBBLE_GAP(T_NG), .T_BYTE_GAP(T_BG), .T_CLEAR(T_CLR)
   ) dut (
      .Clock(Clock),
      .Reset(Reset),
      .bus(bus)
   );

   int n_chk = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   logic [8:0] sb[$];

   // Monitor: pulse widths, init nibbles, byte scoreboard, ready gap.
   logic       e_prev = 1'b0, rdy_prev = 1'b0, hi_done = 1'b0, cur_rs = 1'b0;
   logic [3:0] cur_nib = '0, hi_nib = '0;
   logic [8:0] last_byte = '0, got_b;
   int         e_len = 0, nib_cnt = 0, cyc = 0, last_fall = 0;

   initial forever begin
      @(negedge Clock);
      cyc++;
      if (Reset) begin
         e_prev = 1'b0; rdy_prev = 1'b0; hi_done = 1'b0; nib_cnt = 0;
         sb.delete();
      end else begin
         if (bus.oLCD_E && !e_prev) begin
            e_len = 1; cur_nib = bus.oLCD_Data; cur_rs = bus.oLCD_RS;
         end else if (bus.oLCD_E) begin
            e_len++;
         end else if (e_prev) begin
            chk("e_len", e_len, T_EN);
            chk("nib_stable", {cur_rs, cur_nib}, {bus.oLCD_RS, bus.oLCD_Data});
            last_fall = cyc;
            if (nib_cnt < 4)
               chk("init_nib", {cur_rs, cur_nib}, (nib_cnt < 3) ? 5'h03 : 5'h02);
            else if (!hi_done) begin
               hi_nib = cur_nib; hi_done = 1'b1;
            end else begin
               hi_done = 1'b0;
               got_b = {cur_rs, hi_nib, cur_nib};
               if (sb.size() == 0) chk("sb_empty", {23'd0, got_b}, 32'hffff_ffff);
               else begin
                  last_byte = sb.pop_front();
                  chk("byte", got_b, last_byte);
               end
            end
            nib_cnt++;
         end
         if (bus.oReady && !rdy_prev)
            chk("rdy_gap", cyc - last_fall,
                (!last_byte[8] && (last_byte[7:0] == 8'h01 || last_byte[7:0] == 8'h02))
                ? T_CLR + 1 : T_BG + 1);
         e_prev   = bus.oLCD_E;
         rdy_prev = bus.oReady;
      end
   end

   task automatic push_init();
      sb.push_back(9'h028); sb.push_back(9'h006);
      sb.push_back(9'h00C); sb.push_back(9'h001);
   endtask

   task automatic wait_rdy(output int n);
      n = 0;
      @(negedge Clock);
      while (!bus.oReady && n < 3000) begin n++; @(negedge Clock); end
      if (!bus.oReady) chk("rdy_timeout", 0, 1);
   endtask

   task automatic wait_ack(output int lat);
      lat = 0;
      do begin @(negedge Clock); lat++; end
      while (!bus.oAckCpu && !bus.oAckCmd && lat < 3000);
      if (!bus.oAckCpu && !bus.oAckCmd) chk("ack_timeout", 0, 1);
   endtask

   task automatic send(input bit cmd, input logic [7:0] d, input bit chk_lat);
      int n, lat;
      wait_rdy(n);
      if (cmd) begin bus.iReqCmd = 1'b1; bus.iCmdData = d; end
      else     begin bus.iReqCpu = 1'b1; bus.iCpuData = d; end
      sb.push_back({~cmd, d});
      wait_ack(lat);
      chk(cmd ? "ack_cmd" : "ack_cpu", cmd ? bus.oAckCmd : bus.oAckCpu, 1);
      chk("ack_other", cmd ? bus.oAckCpu : bus.oAckCmd, 0);
      if (chk_lat) begin
         chk("ack_lat", lat, 1);
         chk("rdy_at_ack", bus.oReady, 0);
      end
      bus.iReqCmd = 1'b0;
      bus.iReqCpu = 1'b0;
   endtask

   initial begin
      int n, lat;
      bit lat_ok;
      bus.iReqCpu = 1'b0; bus.iCpuData = '0;
      bus.iReqCmd = 1'b0; bus.iCmdData = '0;

      // Reset state
      repeat (2) @(negedge Clock);
      chk("rst_ack_cpu", bus.oAckCpu, 0);
      chk("rst_ack_cmd", bus.oAckCmd, 0);
      chk("rst_ready", bus.oReady, 0);
      chk("rst_e", bus.oLCD_E, 0);
      chk("rst_rs", bus.oLCD_RS, 0);
      chk("rst_data", bus.oLCD_Data, 0);
      chk("rst_rw", bus.oLCD_RW, 0);
      chk("rst_sfce", bus.oLCD_SF_CE, 1);

      // Init sequence; requests raised during init are held off
      @(posedge Clock); #2 Reset = 1'b0;
      push_init();
      bus.iReqCpu = 1'b1; bus.iCpuData = 8'h41;
      sb.push_back(9'h141);
      wait_rdy(n);
      chk("init_cyc", n, INIT_CYC);
      chk("no_early_ack", bus.oAckCpu, 0);
      wait_ack(lat);
      chk("held_req_ack", bus.oAckCpu, 1);
      chk("held_req_lat", lat, 1);
      bus.iReqCpu = 1'b0;
      wait_rdy(n);
      chk("byte_time_41", n, BYTE_RDY);

      // Single write
      send(1'b0, 8'h41, 1'b1);
      wait_rdy(n);
      chk("byte_time_41b", n, BYTE_RDY);

      // Contention: cmd first (pointer at CPU), cmd held -> CPU next
      wait_rdy(n);
      bus.iReqCpu = 1'b1; bus.iCpuData = 8'h55;
      bus.iReqCmd = 1'b1; bus.iCmdData = 8'h80;
      sb.push_back(9'h080); sb.push_back(9'h155); sb.push_back(9'h014);
      @(negedge Clock);
      chk("cont1_cmd", bus.oAckCmd, 1);
      chk("cont1_cpu", bus.oAckCpu, 0);
      bus.iCmdData = 8'h14;
      wait_ack(lat);
      chk("cont2_cpu", bus.oAckCpu, 1);
      chk("cont2_cmd", bus.oAckCmd, 0);
      bus.iReqCpu = 1'b0;
      wait_ack(lat);
      chk("cont3_cmd", bus.oAckCmd, 1);
      bus.iReqCmd = 1'b0;

      // Clear timing versus normal command
      send(1'b1, 8'h01, 1'b1);
      wait_rdy(n);
      chk("clr_time", n, CLR_RDY);
      send(1'b1, 8'h0C, 1'b1);
      wait_rdy(n);
      chk("0c_time", n, BYTE_RDY);

      // Reset mid-byte
      send(1'b0, 8'h7E, 1'b1);
      n = 0;
      while (!bus.oLCD_E && n < 200) begin @(negedge Clock); n++; end
      @(posedge Clock); #2 Reset = 1'b1;
      chk("e_at_rst", bus.oLCD_E, 1);
      @(posedge Clock); #2 Reset = 1'b0;
      push_init();
      @(negedge Clock);
      chk("mid_rst_e", bus.oLCD_E, 0);
      chk("mid_rst_ack", {bus.oAckCpu, bus.oAckCmd}, 0);
      chk("mid_rst_rdy", bus.oReady, 0);
      wait_rdy(n);
      chk("reinit_cyc", n, INIT_CYC - 1);

      // 32 data bytes; with wrap enabled C0 follows the 16th and 80 the 32nd
      for (int i = 0; i < 32; i++) begin
         lat_ok = 1'b1;
`ifdef LCD_LINE_WRAP_EN
         if (i == 16) lat_ok = 1'b0;
`endif
         send(1'b0, 8'h30 + 8'(i), lat_ok);
`ifdef LCD_LINE_WRAP_EN
         if (i == 15) sb.push_back(9'h0C0);
         if (i == 31) sb.push_back(9'h080);
`endif
      end

      // Drain
      n = 0;
      while ((sb.size() != 0 || !bus.oReady) && n < 3000) begin @(negedge Clock); n++; end
      chk("sb_drain", sb.size(), 0);
      chk("rw_low", bus.oLCD_RW, 0);
      chk("sfce_high", bus.oLCD_SF_CE, 1);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
